grid_cell_writer: RTL and testbench

- Write-side controller for the 1-bit cell framebuffer that the display path reads as mem_pixel.
- The grid is 20x15 cells of 32x32 px over a 640x480 screen.
- Converts mouse position plus button edges into single-cell toggle/clear writes, and runs a clear-all sweep.
- Drives the write port of the dual-port grid RAM and uses that RAM's synchronous read port for read-modify-write.

---
 rtl/grid_pkg.sv | 20 ++
 rtl/cell_addr_calc.sv | 26 ++
 rtl/grid_cell_writer.sv | 138 +++++++++++++
 tb/tb_grid_cell_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared grid geometry and write-controller state encoding.
package grid_pkg;

  localparam int unsigned GRID_COLS  = 20;
  localparam int unsigned GRID_ROWS  = 15;
  localparam int unsigned CELL_SHIFT = 5;
  localparam int unsigned ADDR_W     = 9;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned PX_W       = 10;
  localparam int unsigned CELL_COUNT = GRID_COLS * GRID_ROWS;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_TGL_RD   = 3'd1;
  localparam logic [STATE_W-1:0] ST_TGL_WR   = 3'd2;
  localparam logic [STATE_W-1:0] ST_CLR_CELL = 3'd3;
  localparam logic [STATE_W-1:0] ST_SWEEP    = 3'd4;

endpackage

// File: rtl/cell_addr_calc.sv
// Pixel position to linear cell address, shared with the display read side.
module cell_addr_calc
  import grid_pkg::*;
(
  input  logic [PX_W-1:0]   px_x,
  input  logic [PX_W-1:0]   px_y,
  output logic [ADDR_W-1:0] cell_addr_c,
  output logic              in_range_c
);

  localparam int unsigned FULL_W = 16;

  logic [FULL_W-1:0] col;
  logic [FULL_W-1:0] row;
  logic [FULL_W-1:0] full_addr;

  // Row-major address at full width, truncated to the RAM address width.
  always_comb begin
    col         = FULL_W'(px_x >> CELL_SHIFT);
    row         = FULL_W'(px_y >> CELL_SHIFT);
    full_addr   = row * FULL_W'(GRID_COLS) + col;
    cell_addr_c = ADDR_W'(full_addr);
    in_range_c  = (px_x < PX_W'(SCREEN_W)) && (px_y < PX_W'(SCREEN_H));
  end

endmodule

// File: rtl/grid_cell_writer.sv
// Mouse-driven toggle/clear writer and clear-all sweeper for the cell RAM.
module grid_cell_writer
  import grid_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PX_W-1:0]   mouse_x,
  input  logic [PX_W-1:0]   mouse_y,
  input  logic              left_btn,
  input  logic              right_btn,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELL_COUNT - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  cell_q, cell_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  rd_addr_d, wr_addr_d;
  logic               wr_en_d, wr_data_d, busy_d;
  logic               left_q, right_q;
  logic               left_rise, right_rise;
  logic [ADDR_W-1:0]  cur_addr_c;
  logic               cur_in_range_c;

  cell_addr_calc u_addr (
    .px_x        (mouse_x),
    .px_y        (mouse_y),
    .cell_addr_c (cur_addr_c),
    .in_range_c  (cur_in_range_c)
  );

  // Button history, updated every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      left_q  <= left_btn;
      right_q <= right_btn;
    end
  end

  assign left_rise  = left_btn & ~left_q;
  assign right_rise = right_btn & ~right_q;

  // Next-state and next-output logic; events outside IDLE are dropped.
  always_comb begin
    state_d   = state_q;
    cell_d    = cell_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    busy_d    = busy;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (clear_req) begin
          cnt_d   = '0;
          state_d = ST_SWEEP;
          busy_d  = 1'b1;
        end else if (right_rise) begin
          if (cur_in_range_c) begin
            cell_d  = cur_addr_c;
            state_d = ST_CLR_CELL;
            busy_d  = 1'b1;
          end
        end else if (left_rise && cur_in_range_c) begin
          rd_addr_d = cur_addr_c;
          cell_d    = cur_addr_c;
          state_d   = ST_TGL_RD;
          busy_d    = 1'b1;
        end
      end
      ST_TGL_RD: begin
        state_d = ST_TGL_WR;
      end
      ST_TGL_WR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cell_q;
        wr_data_d = ~rd_data;
        state_d   = ST_IDLE;
      end
      ST_CLR_CELL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cell_q;
        wr_data_d = 1'b0;
        state_d   = ST_IDLE;
      end
      ST_SWEEP: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = 1'b0;
        if (cnt_q == LAST_CELL) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cell_q  <= '0;
      cnt_q   <= '0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cell_q  <= cell_d;
      cnt_q   <= cnt_d;
      rd_addr <= rd_addr_d;
      wr_en   <= wr_en_d;
      wr_addr <= wr_addr_d;
      wr_data <= wr_data_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_grid_cell_writer.sv
// Self-checking bench: randomized clicks and sweeps against a cell-level model.
module tb_grid_cell_writer;

  logic       clk;
  logic       rst_n;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       left_btn;
  logic       right_btn;
  logic       clear_req;
  logic [8:0] rd_addr;
  logic       rd_data;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic       wr_data;
  logic       busy;

  int checks;
  int errors;

  bit   seed_mem [0:511];
  logic ram      [0:511];
  bit   ram_init;
  bit   ref_mem  [0:299];

  grid_cell_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mouse_x   (mouse_x),
    .mouse_y   (mouse_y),
    .left_btn  (left_btn),
    .right_btn (right_btn),
    .clear_req (clear_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Dual-port grid RAM with a one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= seed_mem[i];
    end else if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
    rd_data <= ram[rd_addr];
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_addr(input int x, input int y);
    return (y / 32) * 20 + (x / 32);
  endfunction

  // kind: 0 = left click, 1 = right click, 2 = both buttons together.
  task automatic single_op(input string tag, input int kind, input int x, input int y);
    int  lat, nwr, ga, gd, ea, ed, busy1, busy_end;
    bit  inr;
    inr = (x < 640) && (y < 480);
    ea  = ref_addr(x, y);
    lat = 0; nwr = 0; ga = 0; gd = 0; busy1 = 0; busy_end = 0;
    @(negedge clk);
    mouse_x   = 10'(x);
    mouse_y   = 10'(y);
    left_btn  = (kind != 1);
    right_btn = (kind != 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin
        busy1   = int'(busy);
        mouse_x = 10'($urandom_range(0, 639));
        mouse_y = 10'($urandom_range(0, 479));
      end
      if (wr_en) begin
        nwr++;
        if (lat == 0) begin
          lat = c;
          ga  = int'(wr_addr);
          gd  = int'(wr_data);
        end
      end
      if (c == 6) busy_end = int'(busy);
    end
    left_btn  = 1'b0;
    right_btn = 1'b0;
    check_val({tag, " busy after accept"}, busy1, int'(inr));
    check_val({tag, " busy at end"}, busy_end, 0);
    if (inr) begin
      ed = (kind == 0) ? int'(!ref_mem[ea]) : 0;
      check_val({tag, " write count"}, nwr, 1);
      check_val({tag, " latency"}, lat, (kind == 0) ? 3 : 2);
      check_val({tag, " wr_addr"}, ga, ea);
      check_val({tag, " wr_data"}, gd, ed);
      ref_mem[ea] = (ed != 0);
    end else begin
      check_val({tag, " write count"}, nwr, 0);
    end
  endtask

  task automatic sweep(input string tag, input bit with_btns, input bit clicks);
    int nwr, first, bad_addr, bad_data, busy_bad, busy_end;
    nwr = 0; first = 0; bad_addr = 0; bad_data = 0; busy_bad = 0; busy_end = 1;
    @(negedge clk);
    clear_req = 1'b1;
    if (with_btns) begin
      mouse_x   = 10'($urandom_range(0, 639));
      mouse_y   = 10'($urandom_range(0, 479));
      left_btn  = 1'b1;
      right_btn = 1'b1;
    end
    for (int c = 1; c <= 305; c++) begin
      @(negedge clk);
      if (c == 1) clear_req = 1'b0;
      if (wr_en) begin
        if (int'(wr_addr) != nwr) bad_addr++;
        if (wr_data) bad_data++;
        if (nwr == 0) first = c;
        nwr++;
      end
      if (c <= 301 && !busy) busy_bad++;
      if (c == 302) busy_end = int'(busy);
      if (clicks && c < 250) begin
        mouse_x  = 10'($urandom_range(0, 639));
        mouse_y  = 10'($urandom_range(0, 479));
        left_btn = 1'($urandom_range(0, 1));
      end
      if (c == 250) begin
        left_btn  = 1'b0;
        right_btn = 1'b0;
      end
    end
    check_val({tag, " write count"}, nwr, 300);
    check_val({tag, " first write cycle"}, first, 2);
    check_val({tag, " address sequence errors"}, bad_addr, 0);
    check_val({tag, " nonzero data writes"}, bad_data, 0);
    check_val({tag, " busy low cycles"}, busy_bad, 0);
    check_val({tag, " busy after sweep"}, busy_end, 0);
    for (int i = 0; i < 300; i++) ref_mem[i] = 1'b0;
  endtask

  task automatic reset_mid_sweep();
    bit found;
    found = 1'b0;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (wr_en && wr_addr == 9'd150) found = 1'b1;
    end
    check_val("midreset reached addr 150", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check_val("midreset wr_en", int'(wr_en), 0);
    check_val("midreset busy", int'(busy), 0);
    check_val("midreset wr_addr", int'(wr_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 150; i++) ref_mem[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int mism;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    mouse_x   = '0;
    mouse_y   = '0;
    left_btn  = 1'b0;
    right_btn = 1'b0;
    clear_req = 1'b0;
    ram_init  = 1'b1;
    for (int i = 0; i < 512; i++) seed_mem[i] = 1'($urandom_range(0, 1));
    seed_mem[0] = 1'b0;
    for (int i = 0; i < 300; i++) ref_mem[i] = seed_mem[i];

    repeat (3) @(negedge clk);
    check_val("reset rd_addr", int'(rd_addr), 0);
    check_val("reset wr_en", int'(wr_en), 0);
    check_val("reset wr_addr", int'(wr_addr), 0);
    check_val("reset wr_data", int'(wr_data), 0);
    check_val("reset busy", int'(busy), 0);
    ram_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    single_op("toggle set", 0, 5, 5);
    single_op("toggle clear", 0, 5, 5);
    single_op("clear corner", 1, 639, 479);
    single_op("out of range x", 0, 640, 100);
    single_op("out of range y", 1, 100, 480);
    single_op("right+left", 2, 300, 200);
    sweep("sweep clicks", 1'b0, 1'b1);
    sweep("priority all", 1'b1, 1'b0);
    single_op("after sweep toggle", 0, 320, 240);

    for (int n = 0; n < 40; n++) begin
      single_op("random op", int'($urandom_range(0, 2)),
                int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
    end

    reset_mid_sweep();
    single_op("post reset toggle", 0, 33, 470);
    single_op("post reset clear", 1, 608, 0);

    repeat (2) @(negedge clk);
    mism = 0;
    for (int i = 0; i < 300; i++) begin
      if (ram[i] !== ref_mem[i]) mism++;
    end
    check_val("ram vs model mismatching cells", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
